// File: rtl/seq_mag_comp_pkg.sv
// Shared encodings for the sequential magnitude comparator: result flags and FSM states.
package seq_mag_comp_pkg;

    localparam logic [2:0] RES_GT   = 3'b100;
    localparam logic [2:0] RES_EQ   = 3'b010;
    localparam logic [2:0] RES_LT   = 3'b001;
    localparam logic [2:0] RES_NONE = 3'b000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_mag_comp_four_bit_comp.sv
// FourBitComp: purely combinational unsigned compare of two 4-bit digits.
module FourBitComp (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       gt,
    output logic       eq,
    output logic       lt
);

    assign gt = (a > b);
    assign eq = (a == b);
    assign lt = (a < b);

endmodule

// File: rtl/seq_mag_comp.sv
// Multi-cycle wide magnitude comparator: walks captured operands one nibble per clock,
// MSB first, stopping at the first unequal nibble and registering a one-hot {gt,eq,lt}.
module seq_mag_comp
    import seq_mag_comp_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           result
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_t             state;
    state_t             next_state;
    logic [W-1:0]       op_a;
    logic [W-1:0]       op_b;
    logic [IDX_W-1:0]   idx;
    logic [3:0]         nib_a;
    logic [3:0]         nib_b;
    logic               gt;
    logic               eq;
    logic               lt;
    logic               last_nib;
    logic               load;

    // Constant-index mux keeps every slice in range for any legal NIBBLES.
    always_comb begin
        nib_a = 4'h0;
        nib_b = 4'h0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx == IDX_W'(i)) begin
                nib_a = op_a[4*i +: 4];
                nib_b = op_b[4*i +: 4];
            end
        end
    end

    FourBitComp u_comp (
        .a  (nib_a),
        .b  (nib_b),
        .gt (gt),
        .eq (eq),
        .lt (lt)
    );

    assign last_nib = gt | lt | (idx == '0);
    assign load     = (state == IDLE || state == DONE) && start;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = CMP;
            CMP:     if (last_nib) next_state = DONE;
            DONE:    next_state = start ? CMP : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state  <= IDLE;
            op_a   <= '0;
            op_b   <= '0;
            idx    <= '0;
            result <= RES_NONE;
        end else begin
            state <= next_state;
            if (load) begin
                op_a <= a;
                op_b <= b;
                idx  <= IDX_W'(NIBBLES - 1);
            end else if (state == CMP) begin
                if (last_nib) begin
                    result <= {gt, eq, lt};
                end else begin
                    idx <= idx - 1'b1;
                end
            end
        end
    end

    assign busy = (state == CMP);
    assign done = (state == DONE);

endmodule
